// File: rtl/systolic_seq_ctrl_pkg.sv
// systolic_pkg: shared types and default sizing for the systolic sequencer.
// Contents:
//   seq_state_t   - sequencer FSM state encoding
//   *_DEF         - default values of the top-level parameters
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRELOAD,
        STREAM,
        DONE
    } seq_state_t;

    localparam int NUM_PE_DEF    = 5;
    localparam int FILT_TAPS_DEF = 3;
    localparam int PRE_ROWS_DEF  = 3;
    localparam int ROW_W_DEF     = 8;
    localparam int TILE_W_DEF    = 7;

endpackage

// File: rtl/systolic_seq_ctrl_onehot_ring.sv
// onehot_ring: PE index counter with enable, selectable wrap limit and one-hot decode.
// Ports:
//   clk, nRST  - clock, asynchronous active-low reset
//   en         - advance the index this cycle
//   clr        - force the index to 0 (wins over en)
//   full       - 1: wrap after NUM_PE-1, 0: wrap after NUM_PE-2
//   onehot     - one-hot decode of the current index
//   wrap       - current index is the last one before wrapping
module onehot_ring #(
    parameter int NUM_PE = 5
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              en,
    input  logic              clr,
    input  logic              full,
    output logic [NUM_PE-1:0] onehot,
    output logic              wrap
);

    localparam int IW = $clog2(NUM_PE);
    localparam logic [IW-1:0] LAST_F = IW'(NUM_PE - 1);
    localparam logic [IW-1:0] LAST_P = IW'(NUM_PE - 2);

    logic [IW-1:0] idx;

    assign wrap   = idx == (full ? LAST_F : LAST_P);
    assign onehot = NUM_PE'(1) << idx;

    always_ff @(posedge clk or negedge nRST)
        if (!nRST)
            idx <= '0;
        else if (clr)
            idx <= '0;
        else if (en)
            idx <= wrap ? '0 : idx + 1'b1;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: job sequencer driving PE read/start and filter-tap strobes per tile.
// Ports:
//   clk, nRST                  - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        - job command handshake (ready only in IDLE)
//   cmd_row_len, cmd_col_tiles - rows per tile (0 treated as 1), tiles per job
//   stall                      - hold the sequence, strobes off this cycle
//   abort                      - only with SYSTOLIC_SEQ_ABORT_EN: end the job early
//   pe_read, pe_start          - one-hot PE operand read / compute start
//   filt_read                  - one-hot filter-tap load (first tile only)
//   busy, done, tile_idx       - job status, one-cycle completion pulse, current tile
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int NUM_PE    = NUM_PE_DEF,
    parameter int FILT_TAPS = FILT_TAPS_DEF,
    parameter int PRE_ROWS  = PRE_ROWS_DEF,
    parameter int ROW_W     = ROW_W_DEF,
    parameter int TILE_W    = TILE_W_DEF
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ROW_W-1:0]     cmd_row_len,
    input  logic [TILE_W-1:0]    cmd_col_tiles,
    input  logic                 stall,
`ifdef SYSTOLIC_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic [NUM_PE-1:0]    pe_read,
    output logic [NUM_PE-1:0]    pe_start,
    output logic [FILT_TAPS-1:0] filt_read,
    output logic                 busy,
    output logic                 done,
    output logic [TILE_W-1:0]    tile_idx
);

    seq_state_t          state;
    logic [ROW_W-1:0]    row_cnt, row_len;
    logic [TILE_W-1:0]   tile_cnt, col_tiles, tile_nxt;
    logic                go, wrap, pre_last, row_last;
    logic [NUM_PE-1:0]   ring_oh;

    assign cmd_ready = state == IDLE;
    assign busy      = state == PRELOAD || state == STREAM;
    assign done      = state == DONE;
    assign tile_idx  = tile_cnt;

    // go: the sequence advances and strobes fire this cycle
`ifdef SYSTOLIC_SEQ_ABORT_EN
    assign go = busy && !stall && !abort;
`else
    assign go = busy && !stall;
`endif

    assign tile_nxt = tile_cnt + 1'b1;
    assign pre_last = row_cnt == ROW_W'(PRE_ROWS - 1);
    assign row_last = row_cnt == row_len - 1'b1;

    assign pe_read   = go ? ring_oh : '0;
    assign pe_start  = (go && (state == STREAM || pre_last)) ? ring_oh : '0;
    // low ring bits are zero whenever the index is past the last tap
    assign filt_read = (go && state == PRELOAD && tile_cnt == '0) ? ring_oh[FILT_TAPS-1:0] : '0;

    onehot_ring #(.NUM_PE(NUM_PE)) u_ring (
        .clk    (clk),
        .nRST   (nRST),
        .en     (go),
        .clr    (!busy),
        .full   (state == STREAM),
        .onehot (ring_oh),
        .wrap   (wrap)
    );

    always_ff @(posedge clk or negedge nRST)
        if (!nRST) begin
            state     <= IDLE;
            row_cnt   <= '0;
            tile_cnt  <= '0;
            row_len   <= '0;
            col_tiles <= '0;
        end else begin
            case (state)
                IDLE:
                    if (cmd_valid) begin
                        row_len   <= (cmd_row_len == '0) ? ROW_W'(1) : cmd_row_len;
                        col_tiles <= cmd_col_tiles;
                        row_cnt   <= '0;
                        tile_cnt  <= '0;
                        state     <= (cmd_col_tiles == '0) ? DONE : PRELOAD;
                    end
                PRELOAD:
                    if (go && wrap) begin
                        row_cnt <= pre_last ? '0 : row_cnt + 1'b1;
                        if (pre_last)
                            state <= STREAM;
                    end
                STREAM:
                    if (go && wrap) begin
                        if (row_last) begin
                            row_cnt  <= '0;
                            tile_cnt <= tile_nxt;
                            state    <= (tile_nxt == col_tiles) ? DONE : PRELOAD;
                        end else
                            row_cnt <= row_cnt + 1'b1;
                    end
                DONE:
                    state <= IDLE;
            endcase
`ifdef SYSTOLIC_SEQ_ABORT_EN
            if (abort && busy)
                state <= DONE;
`endif
        end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: self-checking bench for systolic_seq_ctrl (5-PE and 8-PE builds).
module tb_systolic_seq_ctrl;

    localparam int PR = 3;

    typedef struct {
        logic [7:0] pr;
        logic [7:0] ps;
        logic [3:0] fr;
        logic       busy;
        logic       done;
        logic [6:0] tile;
    } rec_t;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       v5 = 1'b0, v8 = 1'b0;
    logic [7:0] row = '0;
    logic [6:0] tiles = '0;
    logic       stall = 1'b0;
    logic       abort = 1'b0;

    logic       rdy5, busy5, done5, rdy8, busy8, done8;
    logic [4:0] pr5, ps5;
    logic [2:0] fr5;
    logic [7:0] pr8, ps8;
    logic [3:0] fr8;
    logic [6:0] tile5, tile8;

    rec_t q[$];
    int   sel = 0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl dut5 (
        .clk           (clk),
        .nRST          (nRST),
        .cmd_valid     (v5),
        .cmd_ready     (rdy5),
        .cmd_row_len   (row),
        .cmd_col_tiles (tiles),
        .stall         (stall),
`ifdef SYSTOLIC_SEQ_ABORT_EN
        .abort         (abort),
`endif
        .pe_read       (pr5),
        .pe_start      (ps5),
        .filt_read     (fr5),
        .busy          (busy5),
        .done          (done5),
        .tile_idx      (tile5)
    );

    systolic_seq_ctrl #(.NUM_PE(8), .FILT_TAPS(4)) dut8 (
        .clk           (clk),
        .nRST          (nRST),
        .cmd_valid     (v8),
        .cmd_ready     (rdy8),
        .cmd_row_len   (row),
        .cmd_col_tiles (tiles),
        .stall         (stall),
`ifdef SYSTOLIC_SEQ_ABORT_EN
        .abort         (abort),
`endif
        .pe_read       (pr8),
        .pe_start      (ps8),
        .filt_read     (fr8),
        .busy          (busy8),
        .done          (done8),
        .tile_idx      (tile8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // expected per-cycle outputs of one job, straight from the phase structure
    task automatic push_job(input int rl, input int ct, input int np, input int ft);
        rec_t r;
        int rows = (rl == 0) ? 1 : rl;
        for (int t = 0; t < ct; t++) begin
            for (int p = 0; p < PR; p++)
                for (int i = 0; i < np - 1; i++) begin
                    r.pr   = 8'd1 << i;
                    r.ps   = (p == PR - 1) ? 8'd1 << i : 8'd0;
                    r.fr   = (t == 0 && i < ft) ? 4'd1 << i : 4'd0;
                    r.busy = 1'b1;
                    r.done = 1'b0;
                    r.tile = 7'(t);
                    q.push_back(r);
                end
            for (int k = 0; k < rows; k++)
                for (int i = 0; i < np; i++) begin
                    r.pr   = 8'd1 << i;
                    r.ps   = 8'd1 << i;
                    r.fr   = 4'd0;
                    r.busy = 1'b1;
                    r.done = 1'b0;
                    r.tile = 7'(t);
                    q.push_back(r);
                end
        end
        r.pr   = 8'd0;
        r.ps   = 8'd0;
        r.fr   = 4'd0;
        r.busy = 1'b0;
        r.done = 1'b1;
        r.tile = 7'(ct);
        q.push_back(r);
    endtask

    task automatic check_now(input logic s);
        logic [7:0] opr, ops;
        logic [3:0] ofr;
        logic       obusy, odone, ordy;
        logic [6:0] otile;
        rec_t       e;
        opr   = sel ? pr8 : {3'b0, pr5};
        ops   = sel ? ps8 : {3'b0, ps5};
        ofr   = sel ? fr8 : {1'b0, fr5};
        obusy = sel ? busy8 : busy5;
        odone = sel ? done8 : done5;
        ordy  = sel ? rdy8 : rdy5;
        otile = sel ? tile8 : tile5;
        if (q.size() == 0) begin
            chk("idle_strobes", {opr, ops, ofr}, 0);
            chk("idle_busy", obusy, 0);
            chk("idle_done", odone, 0);
            chk("idle_ready", ordy, 1);
        end else if (s) begin
            e = q[0];
            chk("stall_strobes", {opr, ops, ofr}, 0);
            chk("stall_busy", obusy, e.busy);
            chk("stall_tile", otile, e.tile);
        end else begin
            e = q.pop_front();
            chk("pe_read", opr, e.pr);
            chk("pe_start", ops, e.ps);
            chk("filt_read", ofr, e.fr);
            chk("busy", obusy, e.busy);
            chk("done", odone, e.done);
            chk("tile_idx", otile, e.tile);
            chk("busy_ready", ordy, 0);
        end
    endtask

    task automatic tick(input logic s);
        stall = s;
        #1;
        check_now(s);
        @(negedge clk);
        stall = 1'b0;
    endtask

    task automatic issue(input int rl, input int ct);
        stall = 1'b0;
        row   = 8'(rl);
        tiles = 7'(ct);
        if (sel != 0) v8 = 1'b1;
        else v5 = 1'b1;
        #1;
        check_now(1'b0);
        push_job(rl, ct, sel ? 8 : 5, sel ? 4 : 3);
        @(negedge clk);
        v5 = 1'b0;
        v8 = 1'b0;
    endtask

    task automatic run_job(input string tag, input int exp_n);
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            tick(1'b0);
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    initial begin
        #1;
        sel = 0;
        check_now(1'b0);
        chk("reset_tile5", tile5, 0);
        sel = 1;
        check_now(1'b0);
        chk("reset_tile8", tile8, 0);
        sel = 0;
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);

        issue(2, 1);
        run_job("job_r2_t1_len", 23);

        issue(2, 0);
        run_job("job_t0_len", 1);

        issue(2, 2);
        run_job("job_r2_t2_len", 45);

        issue(0, 1);
        run_job("job_r0_len", 18);

        issue(2, 1);
        for (int i = 0; i < 14; i++) tick(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1);
        run_job("job_stall_tail", 9);

        issue(2, 1);
        for (int i = 0; i < 5; i++) tick(1'b0);
        nRST = 1'b0;
        q.delete();
        #1;
        check_now(1'b0);
        chk("midreset_tile", tile5, 0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        issue(1, 1);
        run_job("job_after_reset_len", 18);

        sel = 1;
        issue(1, 1);
        run_job("job8_r1_len", 30);

`ifdef SYSTOLIC_SEQ_ABORT_EN
        issue(2, 1);
        for (int i = 0; i < 23; i++) tick(1'b0);
        q.delete();
        abort = 1'b1;
        stall = 1'b1;
        #1;
        chk("abort_strobes", {pr8, ps8, fr8}, 0);
        chk("abort_busy", busy8, 1);
        @(negedge clk);
        abort = 1'b0;
        stall = 1'b0;
        #1;
        chk("abort_done", done8, 1);
        chk("abort_busy_low", busy8, 0);
        @(negedge clk);
        #1;
        chk("abort_ready", rdy8, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
